// File: rtl/prio_event_pkg.sv
// rtl/prio_event_pkg.sv - shared FSM state type and index-width helper for the event encoder
package prio_event_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational wrap-around priority scan, downward from base
module prio_pick
    import prio_event_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    // Step k looks at (base - k) mod N; the first hit in scan order wins.
    always_comb begin
        int p;
        p   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = int'(base) - k;
            if (p < 0) begin
                p = p + N;
            end
            if (!any && vec[W'(p)]) begin
                idx = W'(p);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_event_encoder.sv
// rtl/prio_event_encoder.sv - sticky-pending priority event encoder with valid/ready index output; PRIO_EVENT_RR_EN adds round-robin
module prio_event_encoder
    import prio_event_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending
);

    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   elig;
    logic [N-1:0]   clr_onehot;
    logic [W-1:0]   base;
    logic [W-1:0]   pick;
    logic           pick_any;
    logic           accept;
    logic           issue;

    assign elig = pending & ~mask;

`ifdef PRIO_EVENT_RR_EN
    logic [W-1:0] ptr;

    // Next scan starts just below the last issued index, wrapping to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= TOP_IDX;
        end else if (issue) begin
            ptr <= (pick == '0) ? TOP_IDX : pick - W'(1);
        end
    end

    assign base = ptr;
`else
    assign base = TOP_IDX;
`endif

    prio_pick #(.N(N)) u_pick (
        .vec  (elig),
        .base (base),
        .idx  (pick),
        .any  (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = HOLD;
            HOLD: if (accept && !issue) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A held index is only replaced on acceptance, so mask/en changes never withdraw it.
    always_comb begin
        accept     = out_valid && out_ready;
        issue      = en && pick_any && ((state == IDLE) || accept);
        clr_onehot = '0;
        if (issue) begin
            clr_onehot[pick] = 1'b1;
        end
    end

    // Set has priority over clear so a re-request of the issued index is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            pending   <= (pending & ~clr_onehot) | (en ? req : '0);
            out_valid <= (state_next == HOLD);
            if (issue) begin
                out_idx <= pick;
            end
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// tb/tb_prio_event_encoder.sv - self-checking bench for prio_event_encoder against a behavioural model
module tb_prio_event_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] mask = '0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic [N-1:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0] m_pend;
    logic         m_valid;
    int           m_idx;
    int           m_ptr;

    always #5 clk = ~clk;

    prio_event_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .mask      (mask),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int ref_pick(input logic [N-1:0] p, input logic [N-1:0] m, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start - k + N) % N;
            if (p[j] && !m[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_step();
        int           start;
        int           pk;
        logic         acc;
        logic         iss;
        logic [N-1:0] nxt;
`ifdef PRIO_EVENT_RR_EN
        start = m_ptr;
`else
        start = N - 1;
`endif
        pk  = ref_pick(m_pend, mask, start);
        acc = m_valid && out_ready;
        iss = en && (pk >= 0) && (!m_valid || acc);
        nxt = m_pend;
        if (iss) nxt[pk] = 1'b0;
        if (en) nxt = nxt | req;
        if (iss) begin
            m_valid = 1'b1;
            m_idx   = pk;
            m_ptr   = (pk == 0) ? N - 1 : pk - 1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        m_pend = nxt;
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, "_valid"}, out_valid, m_valid);
        if (m_valid) check({tag, "_idx"}, out_idx, m_idx);
        check({tag, "_pending"}, pending, m_pend);
    endtask

    task automatic drain();
        req = '0; mask = '0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) cyc("drain");
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_idx", out_idx, 0);
        check("reset_pending", pending, 0);
        rst_n = 1'b1;
        en    = 1'b1;

`ifdef PRIO_EVENT_RR_EN
        req = 8'hFF; out_ready = 1'b1;
        cyc("rr_cap");
        for (int i = 0; i < 9; i++) begin
            cyc("rr");
            check("rr_seq", out_idx, (i == 8) ? 7 : 7 - i);
        end
        drain();
        model_reset();
        rst_n = 1'b0; #1; rst_n = 1'b1;
`else
        // Priority order: one-cycle burst drains 7, 5, 2 back to back.
        req = 8'b1010_0100; out_ready = 1'b1;
        cyc("prio_cap");
        req = '0;
        cyc("prio_a"); check("prio_first", out_idx, 7);
        cyc("prio_b"); check("prio_second", out_idx, 5);
        cyc("prio_c"); check("prio_third", out_idx, 2);
        cyc("prio_end"); check("prio_idle", out_valid, 0);
        check("prio_empty", pending, 0);
`endif

        // Backpressure holds index 4 stable.
        req = 8'b0001_0010; out_ready = 1'b0;
        cyc("bp_cap");
        req = '0;
        for (int i = 0; i < 5; i++) cyc("bp_hold");
        check("bp_idx", out_idx, 4);
        check("bp_pending", pending, 8'b0000_0010);
        out_ready = 1'b1;
        cyc("bp_acc4");
        check("bp_next", out_idx, 1);
        drain();

        // Masked bit is retained, issues once unmasked.
        mask = 8'b1000_0000; req = 8'b1000_0001;
        cyc("mask_cap");
        req = '0;
        for (int i = 0; i < 4; i++) cyc("mask_run");
        check("mask_keep7", pending[7], 1);
        mask = '0;
        cyc("unmask_a");
        check("unmask_idx", out_idx, 7);
        drain();

        // Disabled: no capture, no issue; then a held index survives en=0.
        en = 1'b0; req = 8'hFF;
        for (int i = 0; i < 3; i++) cyc("en_off");
        check("en_off_pending", pending, 0);
        en = 1'b1; req = 8'b0000_0110; out_ready = 1'b0;
        cyc("en_cap");
        req = '0;
        cyc("en_issue");
        en = 1'b0; mask = 8'hFF;
        for (int i = 0; i < 3; i++) cyc("en_held");
        out_ready = 1'b1;
        cyc("en_done");
        drain();

        // Set over clear: continuous re-request of 3.
        req = 8'b0000_1000; out_ready = 1'b1;
        cyc("soc_cap");
        for (int i = 0; i < 5; i++) begin
            cyc("soc");
            check("soc_idx", out_idx, 3);
            check("soc_pend3", pending[3], 1);
        end
        drain();

        // Async reset while holding.
        req = 8'b0100_0000; out_ready = 1'b0;
        cyc("ar_cap");
        req = 8'b0000_0001;
        cyc("ar_hold");
        check("ar_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_pending", pending, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; req = '0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req       = N'($urandom) & N'($urandom);
            mask      = N'($urandom) & N'($urandom) & N'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc("rand");
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
